// File: rtl/jtdd_colmix.sv
// Colour mixer: char/obj/scroll priority, dual-port palette RAM and a 3-stage RGB pipeline.
// Define JTDD_LAYER_MASK_EN to add the gfx_en layer-mask input.
module jtdd_colmix #(
  parameter SIMFILE_RG = "pal_rg.bin",
  parameter SIMFILE_B  = "pal_b.bin"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       cen_E,
  input  logic [9:0] cpu_AB,
  input  logic       pal_cs,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  input  logic [6:0] char_pxl,
  input  logic [7:0] obj_pxl,
  input  logic [7:0] scr_pxl,
`ifdef JTDD_LAYER_MASK_EN
  input  logic [2:0] gfx_en,
`endif
  input  logic       LHBL,
  input  logic       LVBL,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  logic [7:0] rg_ram [0:511];
  logic [3:0] b_ram  [0:511];

  logic       cpu_we_s;
  logic       char_on_s;
  logic       obj_on_s;
  logic [8:0] sel_idx_s;
  logic [8:0] idx_r;
  logic [7:0] rg_rd_r;
  logic [3:0] b_rd_r;
  logic [1:0] lhbl_r;
  logic [1:0] lvbl_r;
  logic       show_s;
  logic       unused_s;

  // The file names only label the images a simulation wrapper loads into rg_ram/b_ram.
  if ($bits(SIMFILE_RG) == 0 && $bits(SIMFILE_B) == 0) begin : g_no_preload_names
  end

  // Object palette bit 7 is implied by the object range.
  assign unused_s = obj_pxl[7];
  assign cpu_we_s = rst & pal_cs & ~cpu_wrn & cen_E;

`ifdef JTDD_LAYER_MASK_EN
  logic       scr_on_s;
  logic       kill_s;
  logic [1:0] kill_r;

  assign char_on_s = (char_pxl[3:0] != 4'h0) & gfx_en[0];
  assign obj_on_s  = (obj_pxl[3:0] != 4'h0) & gfx_en[2];
  assign scr_on_s  = gfx_en[1];
  assign show_s    = lhbl_r[1] & lvbl_r[1] & ~kill_r[1];

  // Tracks pixels with every layer masked so they come out black.
  always_ff @(posedge clk) begin
    if (!rst) begin
      kill_r <= 2'b00;
    end else if (pxl_cen) begin
      kill_r <= {kill_r[0], kill_s};
    end
  end
`else
  assign char_on_s = (char_pxl[3:0] != 4'h0);
  assign obj_on_s  = (obj_pxl[3:0] != 4'h0);
  assign show_s    = lhbl_r[1] & lvbl_r[1];
`endif

  // Layer priority: char over object over scroll (scroll is opaque even at colour 0).
  always_comb begin
    sel_idx_s = {1'b1, scr_pxl};
`ifdef JTDD_LAYER_MASK_EN
    kill_s = 1'b0;
`endif
    if (char_on_s) begin
      sel_idx_s = {2'b00, char_pxl};
    end else if (obj_on_s) begin
      sel_idx_s = {2'b01, obj_pxl[6:0]};
`ifdef JTDD_LAYER_MASK_EN
    end else if (!scr_on_s) begin
      sel_idx_s = 9'h100;
      kill_s    = 1'b1;
`endif
    end else begin
      sel_idx_s = {1'b1, scr_pxl};
    end
  end

  // CPU port writes; palette contents survive reset.
  always_ff @(posedge clk) begin
    if (cpu_we_s) begin
      if (cpu_AB[9]) begin
        b_ram[cpu_AB[8:0]] <= cpu_dout[3:0];
      end else begin
        rg_ram[cpu_AB[8:0]] <= cpu_dout;
      end
    end
  end

  // CPU readback, one cen_E behind the address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pal_dout <= 8'h00;
    end else if (cen_E) begin
      pal_dout <= cpu_AB[9] ? {4'h0, b_ram[cpu_AB[8:0]]} : rg_ram[cpu_AB[8:0]];
    end
  end

  // Stages 1 and 2: index register, then video-port palette read; blanks follow alongside.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_r   <= 9'h000;
      rg_rd_r <= 8'h00;
      b_rd_r  <= 4'h0;
      lhbl_r  <= 2'b00;
      lvbl_r  <= 2'b00;
    end else if (pxl_cen) begin
      idx_r   <= sel_idx_s;
      rg_rd_r <= rg_ram[idx_r];
      b_rd_r  <= b_ram[idx_r];
      lhbl_r  <= {lhbl_r[0], LHBL};
      lvbl_r  <= {lvbl_r[0], LVBL};
    end
  end

  // Stage 3: registered RGB, blanked by the same blank values that leave on LHBL_dly/LVBL_dly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      red      <= 4'h0;
      green    <= 4'h0;
      blue     <= 4'h0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      red      <= show_s ? rg_rd_r[3:0] : 4'h0;
      green    <= show_s ? rg_rd_r[7:4] : 4'h0;
      blue     <= show_s ? b_rd_r       : 4'h0;
      LHBL_dly <= lhbl_r[1];
      LVBL_dly <= lvbl_r[1];
    end
  end

endmodule
